// File: rtl/div_iter_if.sv
// Request/response bundle for the iterative divider: the requester drives the
// operands, div_valid and cancel; the divider returns div_ready, complete, s and r.
interface div_iter_if #(
    parameter int DATA_W = 32
);
    logic              div_valid;
    logic              div_signed;
    logic [DATA_W-1:0] x;
    logic [DATA_W-1:0] y;
    logic              cancel;
    logic              div_ready;
    logic              complete;
    logic [DATA_W-1:0] s;
    logic [DATA_W-1:0] r;

    modport master (
        output div_valid, div_signed, x, y, cancel,
        input  div_ready, complete, s, r
    );

    modport slave (
        input  div_valid, div_signed, x, y, cancel,
        output div_ready, complete, s, r
    );
endinterface

// File: rtl/div_iter.sv
// Restoring radix-2 divider, one quotient bit per cycle, signed/unsigned operands.
// Define DIV_ZERO_FAST_EN to let a zero divisor skip straight to DONE.
module div_iter #(
    parameter int DATA_W = 32
) (
    input  logic       clk,
    input  logic       reset,
    div_iter_if.slave  bus
);
    localparam int CNT_W = $clog2(DATA_W);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   dvd_q, dvd_d;
    logic [DATA_W:0]     dvs_q, dvs_d;
    logic [DATA_W:0]     rem_q, rem_d;
    logic [DATA_W-1:0]   quo_q, quo_d;
    logic [DATA_W-1:0]   x_q, x_d;
    logic                neg_quo_q, neg_quo_d;
    logic                neg_rem_q, neg_rem_d;
    logic                yzero_q, yzero_d;
    logic [DATA_W-1:0]   s_q, s_d;
    logic [DATA_W-1:0]   r_q, r_d;

    logic                accept;
    logic                y_is_zero;
    logic                div_ready;
    logic                complete;
    logic [DATA_W+1:0]   trial;
    logic [DATA_W-1:0]   res_s;
    logic [DATA_W-1:0]   res_r;

    // |0x80000000| wraps to 0x80000000, which is the correct unsigned magnitude.
    function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] v,
                                                    input logic             sgn);
        return (sgn && v[DATA_W-1]) ? -v : v;
    endfunction

    assign y_is_zero = (bus.y == '0);
    assign accept    = (state_q == IDLE) && bus.div_valid && !bus.cancel;
    assign trial     = {rem_q, dvd_q[DATA_W-1]} - {1'b0, dvs_q};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            x_q       <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            yzero_q   <= 1'b0;
            s_q       <= '0;
            r_q       <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            x_q       <= x_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            yzero_q   <= yzero_d;
            s_q       <= s_d;
            r_q       <= r_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
`ifdef DIV_ZERO_FAST_EN
                    state_d = y_is_zero ? DONE : CALC;
`else
                    state_d = CALC;
`endif
                end
            end
            CALC: begin
                if (bus.cancel)
                    state_d = IDLE;
                else if (cnt_q == CNT_W'(DATA_W - 1))
                    state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d     = cnt_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        x_d       = x_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        yzero_d   = yzero_q;
        if (accept) begin
            cnt_d     = '0;
            dvd_d     = magnitude(bus.x, bus.div_signed);
            dvs_d     = {1'b0, magnitude(bus.y, bus.div_signed)};
            rem_d     = '0;
            quo_d     = '0;
            x_d       = bus.x;
            neg_quo_d = bus.div_signed && (bus.x[DATA_W-1] ^ bus.y[DATA_W-1]);
            neg_rem_d = bus.div_signed && bus.x[DATA_W-1];
            yzero_d   = y_is_zero;
        end else if (state_q == CALC) begin
            // A negative trial means the divisor did not fit: restore the shifted remainder.
            cnt_d = cnt_q + 1'b1;
            dvd_d = {dvd_q[DATA_W-2:0], 1'b0};
            if (trial[DATA_W+1]) begin
                rem_d = {rem_q[DATA_W-1:0], dvd_q[DATA_W-1]};
                quo_d = {quo_q[DATA_W-2:0], 1'b0};
            end else begin
                rem_d = trial[DATA_W:0];
                quo_d = {quo_q[DATA_W-2:0], 1'b1};
            end
        end
    end

    // The zero-divisor result is forced here so the sign fix-up never touches it.
    always_comb begin
        if (yzero_q) begin
            res_s = '1;
            res_r = x_q;
        end else begin
            res_s = neg_quo_q ? -quo_q : quo_q;
            res_r = neg_rem_q ? -rem_q[DATA_W-1:0] : rem_q[DATA_W-1:0];
        end
    end

    // s/r show the fresh result during the complete cycle and latch it on that edge.
    always_comb begin
        div_ready = (state_q == IDLE);
        complete  = (state_q == DONE) && !bus.cancel;
        s_d       = complete ? res_s : s_q;
        r_d       = complete ? res_r : r_q;
    end

    assign bus.div_ready = div_ready;
    assign bus.complete  = complete;
    assign bus.s         = s_d;
    assign bus.r         = r_d;
endmodule

// File: doc/div_iter.md
DIV_ITER -- requirements
Module: div_iter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports named clk and reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-high; clears all state.
REQ-004 div_valid  input  1  a request is present on x, y and div_signed.
REQ-005 div_signed  input  1  1 = two's-complement operands, 0 = unsigned.
REQ-006 x  input  32  dividend.
REQ-007 y  input  32  divisor.
REQ-008 cancel  input  1  pipeline flush; abandons the division in progress.
REQ-009 div_ready  output  1  the block can accept a request this cycle.
REQ-010 complete  output  1  one-cycle pulse; s and r are valid.
REQ-011 s  output  32  quotient (LO).
REQ-012 r  output  32  remainder (HI).

Function
REQ-013 The block SHALL have three states: IDLE, CALC and DONE; div_ready SHALL be 1 only in IDLE.
REQ-014 A request SHALL be accepted on a rising edge where div_valid=1, div_ready=1 and cancel=0; the operands and div_signed SHALL be latched and the state SHALL go IDLE->CALC.
REQ-015 Operand preparation: signed mode SHALL use |x| and |y| as 33-bit magnitudes (|0x80000000| = 0x80000000); unsigned mode SHALL zero-extend.
REQ-016 CALC SHALL be a restoring divider producing one quotient bit per cycle, MSB first.
REQ-017 Each CALC step: partial = {rem, next dividend bit} - divisor; if the result is >= 0, keep it and set the quotient bit to 1, else restore and set it to 0.
REQ-018 A 5-bit step counter SHALL run from 0 to 31; after the step-31 edge the state SHALL go CALC->DONE.
REQ-019 Sign fix-up in signed mode: quotient negated iff x[31]^y[31]; remainder negated iff x[31]; the remainder sign always follows the dividend.
REQ-020 0x80000000 / 0xFFFFFFFF in signed mode SHALL give s=0x80000000 and r=0; no trap and no flag.
REQ-021 In DONE, complete SHALL be 1 for exactly one cycle, s and r SHALL be updated, and the next edge SHALL return the state to IDLE.
REQ-022 Latency: accept edge at cycle 0; CALC occupies cycles 1-32; complete=1 in cycle 33; div_ready=1 again in cycle 34.
REQ-023 s and r SHALL hold their last result until the next complete; they SHALL NOT change during CALC.
REQ-024 A zero divisor SHALL give s=0xFFFFFFFF and r=x in both signed and unsigned modes.
REQ-025 cancel=1 in CALC or DONE SHALL return the state to IDLE on the next edge, suppress complete, and leave s and r unchanged.
REQ-026 cancel=1 in IDLE SHALL block acceptance of a request in that cycle.
REQ-027 div_valid while div_ready=0 SHALL be ignored; the requester must hold the request until accepted.

Reset
REQ-028 Asserting reset SHALL immediately force: state=IDLE, counter=0, complete=0, s=0, r=0, div_ready=1.
REQ-029 Reset during CALC SHALL abandon the operation; no complete SHALL follow after reset deasserts.
REQ-030 A request SHALL be accepted on the first rising edge after reset deasserts.

Configuration
REQ-031 Macro DIV_ZERO_FAST_EN SHALL select the zero-divisor behaviour.
REQ-032 With DIV_ZERO_FAST_EN defined, an accepted request with y=0 SHALL go IDLE->DONE directly, so complete=1 in cycle 1.
REQ-033 Without DIV_ZERO_FAST_EN, a zero divisor SHALL take the normal 33-cycle path.
REQ-034 Result values for a zero divisor SHALL be identical with and without the macro (REQ-024).

Verification
REQ-035 Unsigned x=100, y=7 -> s=14, r=2, complete in cycle 33, div_ready=1 in cycle 34.
REQ-036 Signed x=0xFFFFFFF9 (-7), y=2 -> s=0xFFFFFFFD, r=0xFFFFFFFF; signed x=7, y=0xFFFFFFFE -> s=0xFFFFFFFD, r=1.
REQ-037 Signed x=0x80000000, y=0xFFFFFFFF -> s=0x80000000, r=0; unsigned x=0xFFFFFFFF, y=1 -> s=0xFFFFFFFF, r=0.
REQ-038 x=5, y=0, either mode -> s=0xFFFFFFFF, r=5; complete in cycle 1 with DIV_ZERO_FAST_EN, cycle 33 without.
REQ-039 Prior result s=14, r=2, then new request with cancel=1 at cycle 10 -> no complete pulse, s=14 and r=2 retained, div_ready=1 in cycle 11; reset asserted at cycle 20 of a second request -> all outputs 0 immediately.
REQ-040 Back-to-back requests with div_valid held high -> second request accepted in cycle 34, its complete in cycle 67.
